pipe_hazard_ctrl: RTL and testbench

- Hazard, stall and forwarding controller for the 5-stage pipelined successor of the single-cycle core (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination/source metadata for ID/EX, EX/MEM and MEM/WB.
- Generates load-use stalls, branch/jump flushes, operand-forwarding selects and a global memory freeze.
- Mode parameters cover a forwarding core and a stall-only core; saturating performance counters report stall and flush cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// shadow-stage metadata records and the destination-match helper.
package pipe_pkg;

    // Register address width the shadow records are built with; the
    // controller's REG_AW parameter defaults to this value and must track it.
    localparam int META_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // Destination metadata carried by every shadow stage.
    typedef struct packed {
        logic               valid;
        logic [META_AW-1:0] rd;
        logic               regwrite;
        logic               memread;
    } stage_meta_t;

    // ID/EX additionally remembers which sources the instruction reads,
    // because forwarding selects are computed for the instruction in EX.
    typedef struct packed {
        stage_meta_t        meta;
        logic [META_AW-1:0] rs1;
        logic [META_AW-1:0] rs2;
        logic               use1;
        logic               use2;
    } idex_meta_t;

    // True when the stage will write register src; x0 never counts.
    function automatic logic dest_hit(stage_meta_t s, logic [META_AW-1:0] src);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard
// controller (slave). The master presents the decoded ID instruction plus
// EX redirect and memory busy; the slave returns stall/flush/freeze
// controls, EX operand selects and event counters. All signals are
// level-sensitive and sampled at the pipeline clock edge; there is no
// valid/ready pairing because every field is evaluated every cycle.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_redirect;
    logic              mem_busy;

    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              flush_ex;
    logic              freeze;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, ex_redirect, mem_busy,
        input  stall_if, stall_id, flush_id, flush_ex, freeze,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, ex_redirect, mem_busy,
        output stall_if, stall_id, flush_id, flush_ex, freeze,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count each cycle with inc high, holding once all ones is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage pipeline.
// Tracks destination metadata for ID/EX, EX/MEM and MEM/WB in a shadow
// pipeline and derives load-use / RAW stalls, redirect flushes, EX operand
// forwarding selects and the global memory freeze.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW    = META_AW,
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    idex_meta_t  idex_q;
    stage_meta_t exmem_q;
    stage_meta_t memwb_q;
    idex_meta_t  id_entry;

    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;

    logic rs1_live, rs2_live;
    logic hit_idex, hit_exmem, hit_memwb;
    logic raw_hazard;

    logic stall_if, stall_id, flush_id, flush_ex, freeze;
    fwd_sel_t fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign id_rs1 = bus.id_rs1;
    assign id_rs2 = bus.id_rs2;
    assign id_rd  = bus.id_rd;

    // Pack the ID instruction into the record that ID/EX will capture.
    always_comb begin
        id_entry               = '0;
        id_entry.meta.valid    = bus.id_valid;
        id_entry.meta.rd       = id_rd;
        id_entry.meta.regwrite = bus.id_regwrite;
        id_entry.meta.memread  = bus.id_memread;
        id_entry.rs1           = id_rs1;
        id_entry.rs2           = id_rs2;
        id_entry.use1          = bus.id_use_rs1;
        id_entry.use2          = bus.id_use_rs2;
    end

    // Match the ID sources against each older in-flight destination.
    always_comb begin
        rs1_live  = bus.id_valid && bus.id_use_rs1 && (id_rs1 != '0);
        rs2_live  = bus.id_valid && bus.id_use_rs2 && (id_rs2 != '0);
        hit_idex  = (rs1_live && dest_hit(idex_q.meta, id_rs1)) ||
                    (rs2_live && dest_hit(idex_q.meta, id_rs2));
        hit_exmem = (rs1_live && dest_hit(exmem_q, id_rs1)) ||
                    (rs2_live && dest_hit(exmem_q, id_rs2));
        hit_memwb = (rs1_live && dest_hit(memwb_q, id_rs1)) ||
                    (rs2_live && dest_hit(memwb_q, id_rs2));
    end

    // Decide whether the ID instruction must wait. With forwarding only a
    // load directly ahead blocks; without it any older writer still in
    // flight does. Without RF write-through a WB writer blocks as well.
    always_comb begin
        raw_hazard = 1'b0;
        if (FWD_EN) begin
            raw_hazard = hit_idex && idex_q.meta.memread;
        end else begin
            raw_hazard = hit_idex || hit_exmem;
        end
        if (!RF_BYPASS) begin
            raw_hazard = raw_hazard || hit_memwb;
        end
    end

    // Pipeline control: freeze beats redirect, redirect beats stall.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        freeze   = bus.mem_busy;
        if (!bus.mem_busy) begin
            if (bus.ex_redirect) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (raw_hazard) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    // EX operand selects for the instruction now in ID/EX; the younger
    // EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN && idex_q.meta.valid) begin
            if (idex_q.use1) begin
                if (dest_hit(exmem_q, idex_q.rs1)) begin
                    fwd_a = FWD_EXMEM;
                end else if (dest_hit(memwb_q, idex_q.rs1)) begin
                    fwd_a = FWD_MEMWB;
                end
            end
            if (idex_q.use2) begin
                if (dest_hit(exmem_q, idex_q.rs2)) begin
                    fwd_b = FWD_EXMEM;
                end else if (dest_hit(memwb_q, idex_q.rs2)) begin
                    fwd_b = FWD_MEMWB;
                end
            end
        end
    end

    // Advance the shadow pipeline unless frozen; a flush_ex inserts a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else if (!freeze) begin
            idex_q  <= flush_ex ? '0 : id_entry;
            exmem_q <= idex_q.meta;
            memwb_q <= exmem_q;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_id),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_id),
        .count (flush_cnt)
    );

    assign bus.stall_if  = stall_if;
    assign bus.stall_id  = stall_id;
    assign bus.flush_id  = flush_id;
    assign bus.flush_ex  = flush_ex;
    assign bus.freeze    = freeze;
    assign bus.fwd_a     = fwd_a;
    assign bus.fwd_b     = fwd_b;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding core (A) and a stall-only core
// without RF write-through (B) see identical stimulus. A model of the
// instructions in flight predicts every output of both each cycle.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_a ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if_b ();

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
        int rs1;
        bit u1;
        int rs2;
        bit u2;
    } ins_t;

    // [core][age]: 0 = in EX, 1 = in MEM, 2 = in WB
    ins_t  inflight[2][3];
    int    m_stalls[2];
    int    m_flushes[2];
    bit    cfg_fwd[2] = '{1'b1, 1'b0};
    bit    cfg_byp[2] = '{1'b1, 1'b0};
    string cfg_name[2] = '{"A", "B"};
    localparam int CNT_MAX = 65535;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic ins_t mk(bit v, int rd, bit rw, bit mr, int rs1, bit u1, int rs2, bit u2);
        ins_t r;
        r.v = v; r.rd = rd; r.rw = rw; r.mr = mr;
        r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        return r;
    endfunction

    function automatic ins_t alu(int rd, int rs1, int rs2);
        return mk(1'b1, rd, 1'b1, 1'b0, rs1, 1'b1, rs2, 1'b1);
    endfunction

    function automatic ins_t load(int rd, int base);
        return mk(1'b1, rd, 1'b1, 1'b1, base, 1'b1, 0, 1'b0);
    endfunction

    function automatic ins_t nop();
        return mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r;
        r.v   = ($urandom_range(0, 99) < 85);
        r.rd  = $urandom_range(0, 3);
        r.rw  = ($urandom_range(0, 3) != 0);
        r.mr  = r.rw && ($urandom_range(0, 2) == 0);
        r.rs1 = $urandom_range(0, 3);
        r.u1  = $urandom_range(0, 1);
        r.rs2 = $urandom_range(0, 3);
        r.u2  = $urandom_range(0, 1);
        return r;
    endfunction

    // An older instruction that will deliver a new value for register r.
    function automatic bit writes(ins_t s, int r);
        return s.v && s.rw && (s.rd != 0) && (s.rd == r);
    endfunction

    // Must the ID instruction wait on core c?
    function automatic bit must_wait(int c, ins_t id);
        bit w = 1'b0;
        int srcs[2];
        bit used[2];
        srcs[0] = id.rs1; used[0] = id.u1;
        srcs[1] = id.rs2; used[1] = id.u2;
        for (int k = 0; k < 2; k++) begin
            if (id.v && used[k] && srcs[k] != 0) begin
                if (cfg_fwd[c]) begin
                    if (writes(inflight[c][0], srcs[k]) && inflight[c][0].mr) w = 1'b1;
                end else begin
                    if (writes(inflight[c][0], srcs[k]) || writes(inflight[c][1], srcs[k])) w = 1'b1;
                end
                if (!cfg_byp[c] && writes(inflight[c][2], srcs[k])) w = 1'b1;
            end
        end
        return w;
    endfunction

    // Where the EX instruction of core c gets an operand from.
    function automatic int source_of(int c, bit used, int r);
        if (!cfg_fwd[c] || !inflight[c][0].v || !used) return 0;
        if (writes(inflight[c][1], r)) return 1;
        if (writes(inflight[c][2], r)) return 2;
        return 0;
    endfunction

    function automatic logic [40:0] observe(int c);
        if (c == 0)
            return {if_a.stall_if, if_a.stall_id, if_a.flush_id, if_a.flush_ex, if_a.freeze,
                    if_a.fwd_a, if_a.fwd_b, if_a.stall_cnt, if_a.flush_cnt};
        return {if_b.stall_if, if_b.stall_id, if_b.flush_id, if_b.flush_ex, if_b.freeze,
                if_b.fwd_a, if_b.fwd_b, if_b.stall_cnt, if_b.flush_cnt};
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 3; s++) inflight[c][s] = nop();
            m_stalls[c]  = 0;
            m_flushes[c] = 0;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input ins_t ins, input bit redir, input bit busy);
        if_a.id_valid    = ins.v;       if_b.id_valid    = ins.v;
        if_a.id_rd       = 5'(ins.rd);  if_b.id_rd       = 5'(ins.rd);
        if_a.id_regwrite = ins.rw;      if_b.id_regwrite = ins.rw;
        if_a.id_memread  = ins.mr;      if_b.id_memread  = ins.mr;
        if_a.id_rs1      = 5'(ins.rs1); if_b.id_rs1      = 5'(ins.rs1);
        if_a.id_use_rs1  = ins.u1;      if_b.id_use_rs1  = ins.u1;
        if_a.id_rs2      = 5'(ins.rs2); if_b.id_rs2      = 5'(ins.rs2);
        if_a.id_use_rs2  = ins.u2;      if_b.id_use_rs2  = ins.u2;
        if_a.ex_redirect = redir;       if_b.ex_redirect = redir;
        if_a.mem_busy    = busy;        if_b.mem_busy    = busy;
    endtask

    // One cycle: present inputs, check both cores against the model,
    // then advance the model across the coming clock edge.
    task automatic step(input ins_t ins, input bit redir, input bit busy);
        bit exp_sd[2];
        bit exp_fi[2];
        bit exp_fe[2];
        @(negedge clk);
        drive(ins, redir, busy);
        #1;
        for (int c = 0; c < 2; c++) begin
            logic [40:0] o;
            bit w;
            int fa, fb;
            w = must_wait(c, ins);
            exp_sd[c] = 1'b0; exp_fi[c] = 1'b0; exp_fe[c] = 1'b0;
            if (!busy) begin
                if (redir) begin
                    exp_fi[c] = 1'b1;
                    exp_fe[c] = 1'b1;
                end else if (w) begin
                    exp_sd[c] = 1'b1;
                    exp_fe[c] = 1'b1;
                end
            end
            fa = source_of(c, inflight[c][0].u1, inflight[c][0].rs1);
            fb = source_of(c, inflight[c][0].u2, inflight[c][0].rs2);
            o = observe(c);
            chk({cfg_name[c], ".stall_if"},  32'(o[40]),    32'(exp_sd[c]));
            chk({cfg_name[c], ".stall_id"},  32'(o[39]),    32'(exp_sd[c]));
            chk({cfg_name[c], ".flush_id"},  32'(o[38]),    32'(exp_fi[c]));
            chk({cfg_name[c], ".flush_ex"},  32'(o[37]),    32'(exp_fe[c]));
            chk({cfg_name[c], ".freeze"},    32'(o[36]),    32'(busy));
            chk({cfg_name[c], ".fwd_a"},     32'(o[35:34]), fa);
            chk({cfg_name[c], ".fwd_b"},     32'(o[33:32]), fb);
            chk({cfg_name[c], ".stall_cnt"}, 32'(o[31:16]), m_stalls[c]);
            chk({cfg_name[c], ".flush_cnt"}, 32'(o[15:0]),  m_flushes[c]);
        end
        // A load still in MEM can never be a forwarding source.
        if (if_a.fwd_a == 2'b01 || if_a.fwd_b == 2'b01)
            chk("A.no_fwd_from_load", 32'(inflight[0][1].mr), 0);
        if (!busy) begin
            for (int c = 0; c < 2; c++) begin
                inflight[c][2] = inflight[c][1];
                inflight[c][1] = inflight[c][0];
                inflight[c][0] = exp_fe[c] ? nop() : ins;
                if (exp_sd[c] && m_stalls[c] < CNT_MAX)  m_stalls[c]++;
                if (exp_fi[c] && m_flushes[c] < CNT_MAX) m_flushes[c]++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(nop(), 1'b0, 1'b0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        rst = 1'b1;
        drive(nop(), 1'b0, 1'b0);
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        chk("reset.A.stall_id",  32'(if_a.stall_id),  0);
        chk("reset.A.flush_ex",  32'(if_a.flush_ex),  0);
        chk("reset.A.fwd_a",     32'(if_a.fwd_a),     0);
        chk("reset.A.stall_cnt", 32'(if_a.stall_cnt), 0);
        chk("reset.B.flush_cnt", 32'(if_b.flush_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back ALU: add x5; sub x6,x5,x1; reader of x5
        step(alu(5, 1, 2), 1'b0, 1'b0);
        step(alu(6, 5, 1), 1'b0, 1'b0);
        chk("b2b.no_stall", 32'(if_a.stall_id), 0);
        step(alu(7, 5, 0), 1'b0, 1'b0);
        chk("b2b.fwd_exmem", 32'(if_a.fwd_a), 1);
        step(nop(), 1'b0, 1'b0);
        chk("b2b.fwd_memwb", 32'(if_a.fwd_a), 2);

        // load-use: lw x7; add x8,x7,x7 (held one cycle)
        do_reset();
        step(load(7, 1), 1'b0, 1'b0);
        step(alu(8, 7, 7), 1'b0, 1'b0);
        chk("lu.stall_if", 32'(if_a.stall_if), 1);
        chk("lu.stall_id", 32'(if_a.stall_id), 1);
        chk("lu.flush_ex", 32'(if_a.flush_ex), 1);
        step(alu(8, 7, 7), 1'b0, 1'b0);
        chk("lu.released", 32'(if_a.stall_id), 0);
        chk("lu.stall_cnt", 32'(if_a.stall_cnt), 1);
        step(nop(), 1'b0, 1'b0);
        chk("lu.fwd_a", 32'(if_a.fwd_a), 2);
        chk("lu.fwd_b", 32'(if_a.fwd_b), 2);

        // x0 writer followed by x0 reader
        do_reset();
        step(alu(0, 1, 2), 1'b0, 1'b0);
        step(alu(9, 0, 0), 1'b0, 1'b0);
        chk("x0.A.no_stall", 32'(if_a.stall_id), 0);
        chk("x0.B.no_stall", 32'(if_b.stall_id), 0);
        step(nop(), 1'b0, 1'b0);
        chk("x0.fwd_a", 32'(if_a.fwd_a), 0);
        chk("x0.fwd_b", 32'(if_a.fwd_b), 0);

        // stall-only core: add x3 then reader of x3
        do_reset();
        step(alu(3, 1, 2), 1'b0, 1'b0);
        n = 0;
        repeat (4) begin
            step(alu(4, 3, 3), 1'b0, 1'b0);
            n += int'(if_b.stall_id);
        end
        chk("stallmode.cycles", n, 3);
        step(nop(), 1'b0, 1'b0);
        chk("stallmode.stall_cnt", 32'(if_b.stall_cnt), 3);

        // redirect in the same cycle as a load-use match
        do_reset();
        step(load(7, 1), 1'b0, 1'b0);
        step(alu(8, 7, 7), 1'b1, 1'b0);
        chk("redir.flush_id", 32'(if_a.flush_id), 1);
        chk("redir.flush_ex", 32'(if_a.flush_ex), 1);
        chk("redir.stall_id", 32'(if_a.stall_id), 0);
        step(nop(), 1'b0, 1'b0);
        chk("redir.flush_cnt", 32'(if_a.flush_cnt), 1);
        chk("redir.stall_cnt", 32'(if_a.stall_cnt), 0);

        // freeze for 4 cycles during a load-use
        do_reset();
        step(load(7, 1), 1'b0, 1'b0);
        repeat (4) begin
            step(alu(8, 7, 7), 1'b0, 1'b1);
            chk("frz.freeze", 32'(if_a.freeze), 1);
            chk("frz.stall_id", 32'(if_a.stall_id), 0);
            chk("frz.stall_cnt", 32'(if_a.stall_cnt), 0);
        end
        step(alu(8, 7, 7), 1'b0, 1'b0);
        chk("frz.resume_stall", 32'(if_a.stall_id), 1);
        step(alu(8, 7, 7), 1'b0, 1'b0);
        chk("frz.stall_cnt_after", 32'(if_a.stall_cnt), 1);

        // asynchronous reset in the middle of a stall
        do_reset();
        step(load(7, 1), 1'b0, 1'b0);
        step(alu(8, 7, 7), 1'b0, 1'b0);
        chk("rst.pre_stall", 32'(if_a.stall_id), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst.A.stall_if", 32'(if_a.stall_if), 0);
        chk("rst.A.stall_id", 32'(if_a.stall_id), 0);
        chk("rst.A.flush_ex", 32'(if_a.flush_ex), 0);
        chk("rst.B.stall_id", 32'(if_b.stall_id), 0);
        chk("rst.A.fwd_a",    32'(if_a.fwd_a),    0);
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        step(alu(8, 7, 7), 1'b0, 1'b0);
        step(nop(), 1'b0, 1'b0);
        chk("rst.no_fwd", 32'(if_a.fwd_a), 0);

        // random traffic over a small register set
        do_reset();
        repeat (400) begin
            step(rnd_ins(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        step(nop(), 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
